// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally and
// registers instruction+PC into a valid/ready IF/ID stage. Optional macro FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus8
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] PC_ALIGN = 32'hFFFF_FFFC;

    state_t      state;
    logic [31:0] pc;

    // Memory decodes only the low IMEM_AW bits of the word index, so fetch aliases.
    if (IMEM_AW < 1 || IMEM_AW > 30) begin : g_aw_check
        $error("fetch_unit: IMEM_AW out of range 1..30");
    end

    assign imem_addr    = {2'b00, pc[31:2]};
    assign out_pc_plus8 = out_pc + 32'd8;

    // PC, IF/ID register and state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC & PC_ALIGN;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_pc    <= 32'd0;
            state     <= S_BOOT;
        end else begin
            case (state)
                S_BOOT: begin
                    if (branch_en) begin
                        pc <= branch_target & PC_ALIGN;
                    end
                    state <= S_RUN;
                end
                S_RUN, S_HOLD: begin
                    // Redirect drops both the held word and the word being read now.
                    if (branch_en) begin
                        pc        <= branch_target & PC_ALIGN;
                        out_valid <= 1'b0;
                        state     <= S_RUN;
                    end else if (out_valid && !out_ready) begin
                        state <= S_HOLD;
                    end else if (fetch_en) begin
                        out_instr <= imem_data;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + 32'd4;
                        state     <= S_RUN;
                    end else begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                        state <= S_RUN;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Handshake and stall counters, free-running with natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= 32'd0;
            perf_stalls  <= 32'd0;
        end else begin
            if (out_valid && out_ready) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {instr, pc} pairs, a
// negedge monitor pops and compares on every handshake; a second instance covers PC wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en, fetch_en1;
    logic        branch_en, branch_en1;
    logic [31:0] branch_target, branch_target1;
    logic        out_ready, out_ready1;

    logic [31:0] imem_addr0, imem_data0, out_instr0, out_pc0, out_pc_plus8_0;
    logic        out_valid0;
    logic [31:0] imem_addr1, imem_data1, out_instr1, out_pc1, out_pc_plus8_1;
    logic        out_valid1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched0, perf_stalls0, perf_fetched1, perf_stalls1;
`endif

    logic [31:0] mem [0:1023];
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          hs_count = 0;
    int          hs_base  = 0;

    always #5 clk = ~clk;

    assign imem_data0 = mem[imem_addr0[9:0]];
    assign imem_data1 = mem[imem_addr1[9:0]];

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut0 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_addr(imem_addr0), .imem_data(imem_data0),
        .branch_en(branch_en), .branch_target(branch_target),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_instr(out_instr0), .out_pc(out_pc0), .out_pc_plus8(out_pc_plus8_0)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched0), .perf_stalls(perf_stalls0)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(10)) dut1 (
        .clk(clk), .rst(rst), .fetch_en(fetch_en1),
        .imem_addr(imem_addr1), .imem_data(imem_data1),
        .branch_en(branch_en1), .branch_target(branch_target1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_instr(out_instr1), .out_pc(out_pc1), .out_pc_plus8(out_pc_plus8_1)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched1), .perf_stalls(perf_stalls1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        exp_q.push_back({instr, pc});
    endtask

    task automatic do_reset(input int n);
        chk("sb_drained_before_reset", 32'(exp_q.size()), 32'd0);
        rst       = 1'b1;
        out_ready = 1'b0;
        branch_en = 1'b0;
        fetch_en  = 1'b1;
        for (int k = 0; k < n; k++) begin
            cyc();
            chk("rst_valid", {31'd0, out_valid0}, 32'd0);
            chk("rst_imem_addr", imem_addr0, 32'd0);
            chk("rst_out_pc", out_pc0, 32'd0);
            chk("rst_out_instr", out_instr0, 32'd0);
        end
        rst     = 1'b0;
        hs_base = hs_count;
        cyc();
        chk("boot_no_capture", {31'd0, out_valid0}, 32'd0);
    endtask

    // Scoreboard monitor: a transfer is out_valid && out_ready ahead of the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid0 === 1'b1 && out_ready === 1'b1) begin
            logic [63:0] e;
            hs_count = hs_count + 1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_extra: handshake of out_pc=%h, expected no transfer", out_pc0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", out_instr0, e[63:32]);
                chk("sb_pc", out_pc0, e[31:0]);
                chk("sb_pc_plus8", out_pc_plus8_0, e[31:0] + 32'd8);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fetch_en = 1'b1; fetch_en1 = 1'b0; out_ready = 1'b0; out_ready1 = 1'b1;
        branch_en = 1'b0; branch_en1 = 1'b0; branch_target = 32'd0; branch_target1 = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hE100_0000 | 32'(i);
        mem[0] = 32'hE280_0002;

        // Reset and streaming
        do_reset(2);
        push(32'hE280_0002, 32'h0); push(32'hE100_0001, 32'h4);
        push(32'hE100_0002, 32'h8); push(32'hE100_0003, 32'hC);
        out_ready = 1'b1;
        cyc();
        chk("first_valid", {31'd0, out_valid0}, 32'd1);
        chk("first_instr", out_instr0, 32'hE280_0002);
        chk("first_pc", out_pc0, 32'h0);
        cyc(); cyc(); cyc();
        chk("stream_pc_c", out_pc0, 32'hC);
        chk("stream_plus8_14", out_pc_plus8_0, 32'h14);
        cyc();
        chk("stream_pc_10", out_pc0, 32'h10);

        // Stall for three cycles at out_pc=4, then drain with fetch_en low
        do_reset(2);
        push(32'hE280_0002, 32'h0); push(32'hE100_0001, 32'h4); push(32'hE100_0002, 32'h8);
        out_ready = 1'b1;
        cyc(); cyc();
        chk("stall_pre_pc", out_pc0, 32'h4);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_valid", {31'd0, out_valid0}, 32'd1);
            chk("stall_pc", out_pc0, 32'h4);
            chk("stall_instr", out_instr0, 32'hE100_0001);
            chk("stall_imem_addr", imem_addr0, 32'h2);
        end
        out_ready = 1'b1;
        cyc();
        chk("after_stall_pc", out_pc0, 32'h8);
        fetch_en = 1'b0;
        cyc();
        chk("drain_valid", {31'd0, out_valid0}, 32'd0);
        chk("idle_imem_addr", imem_addr0, 32'h3);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stalls", perf_stalls0, 32'd3);
        chk("perf_fetched_const", perf_fetched0, 32'd3);
        chk("perf_fetched_seen", perf_fetched0, 32'(hs_count - hs_base));
`endif

        // Redirect while out_pc=8
        do_reset(2);
        push(32'hE280_0002, 32'h0); push(32'hE100_0001, 32'h4); push(32'hE100_0002, 32'h8);
        push(32'hE100_0010, 32'h40); push(32'hE100_0011, 32'h44);
        out_ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("br_pre_pc", out_pc0, 32'h8);
        branch_en = 1'b1; branch_target = 32'h42;
        cyc();
        branch_en = 1'b0;
        chk("br_bubble", {31'd0, out_valid0}, 32'd0);
        chk("br_imem_addr", imem_addr0, 32'h10);
        cyc();
        chk("br_valid", {31'd0, out_valid0}, 32'd1);
        chk("br_pc", out_pc0, 32'h40);
        chk("br_instr", out_instr0, 32'hE100_0010);
        cyc();
        chk("br_next_pc", out_pc0, 32'h44);
        fetch_en = 1'b0;
        cyc();
        chk("br_drain", {31'd0, out_valid0}, 32'd0);

        // Branch while decode is stalled: held word is flushed
        do_reset(2);
        push(32'hE280_0002, 32'h0); push(32'hE100_0040, 32'h100);
        out_ready = 1'b1;
        cyc(); cyc();
        chk("bs_pre_pc", out_pc0, 32'h4);
        out_ready = 1'b0;
        cyc();
        chk("bs_hold_pc", out_pc0, 32'h4);
        branch_en = 1'b1; branch_target = 32'h100;
        cyc();
        branch_en = 1'b0;
        chk("bs_flush", {31'd0, out_valid0}, 32'd0);
        chk("bs_imem_addr", imem_addr0, 32'h40);
        out_ready = 1'b1;
        cyc();
        chk("bs_valid", {31'd0, out_valid0}, 32'd1);
        chk("bs_pc", out_pc0, 32'h100);
        chk("bs_instr", out_instr0, 32'hE100_0040);
        fetch_en = 1'b0;
        cyc();
        chk("bs_drain", {31'd0, out_valid0}, 32'd0);

        // PC wrap on the second instance
        do_reset(2);
        fetch_en  = 1'b0;
        fetch_en1 = 1'b1;
        chk("wrap_imem_addr", imem_addr1, 32'h3FFF_FFFE);
        cyc();
        chk("wrap_valid", {31'd0, out_valid1}, 32'd1);
        chk("wrap_pc0", out_pc1, 32'hFFFF_FFF8);
        chk("wrap_instr0", out_instr1, 32'hE100_03FE);
        chk("wrap_plus8_0", out_pc_plus8_1, 32'h0);
        cyc();
        chk("wrap_pc1", out_pc1, 32'hFFFF_FFFC);
        chk("wrap_instr1", out_instr1, 32'hE100_03FF);
        chk("wrap_plus8_1", out_pc_plus8_1, 32'h4);
        cyc();
        chk("wrap_pc2", out_pc1, 32'h0);
        chk("wrap_instr2", out_instr1, 32'hE280_0002);
        fetch_en1 = 1'b0;
        cyc();

        chk("sb_drained_end", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
